// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the memory wrapper that sizes
// its shift register from the same FSM image parameters.
package prog_loader_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BYTE = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // Image size: constants first, then one record per FSM state.
    function automatic int mem_width(input int state_count, input int cond_width,
                                     input int output_width, input int action_width,
                                     input int counter_width, input int counter_count);
        return counter_width * counter_count +
               state_count * ($clog2(state_count) + 2 + output_width + cond_width + 2 * action_width);
    endfunction

    function automatic int slices_per_byte(input int byte_width, input int input_width);
        return byte_width / input_width;
    endfunction

endpackage

// File: rtl/prog_loader_byte_serializer.sv
// Holds one program byte and emits it MSB first as INPUT_WIDTH-bit slices,
// one per cycle, with registered slice outputs.
module byte_serializer #(
    parameter int INPUT_WIDTH = 1,
    parameter int BYTE_WIDTH  = 8,
    parameter int CNT_W       = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   load,
    input  logic [BYTE_WIDTH-1:0]  load_data,
    input  logic [CNT_W-1:0]       load_count,
    output logic                   slice_valid,
    output logic [INPUT_WIDTH-1:0] slice,
    output logic                   last_slice
);

    logic [BYTE_WIDTH-1:0] buffer;
    logic [CNT_W-1:0]      count;

    // The first slice goes straight out on the load edge so the byte's
    // slices occupy the cycles immediately after the handshake.
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            slice_valid <= 1'b0;
            slice       <= '0;
            buffer      <= '0;
            count       <= '0;
        end else if (load) begin
            slice_valid <= 1'b1;
            slice       <= load_data[BYTE_WIDTH-1 -: INPUT_WIDTH];
            buffer      <= load_data << INPUT_WIDTH;
            count       <= load_count;
        end else if (slice_valid) begin
            if (count == CNT_W'(1)) begin
                slice_valid <= 1'b0;
                slice       <= '0;
                count       <= '0;
            end else begin
                slice  <= buffer[BYTE_WIDTH-1 -: INPUT_WIDTH];
                buffer <= buffer << INPUT_WIDTH;
                count  <= count - CNT_W'(1);
            end
        end
    end

    assign last_slice = slice_valid && (count == CNT_W'(1));

endmodule

// File: rtl/prog_loader.sv
// Loads a complete FSM image into the memory shift register and only lets the
// FSM core run once every bit of the image has been shifted in.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INPUT_WIDTH   = 1,
    parameter int BYTE_WIDTH    = 8,
    parameter int STATE_COUNT   = 8,
    parameter int COND_WIDTH    = 1,
    parameter int OUTPUT_WIDTH  = 4,
    parameter int ACTION_WIDTH  = 1,
    parameter int COUNTER_WIDTH = 16,
    parameter int COUNTER_COUNT = 2,
    localparam int MEM_WIDTH = mem_width(STATE_COUNT, COND_WIDTH, OUTPUT_WIDTH,
                                         ACTION_WIDTH, COUNTER_WIDTH, COUNTER_COUNT),
    localparam int BL_W      = $clog2(MEM_WIDTH + 1)
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [BYTE_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   prog_enable,
    output logic [INPUT_WIDTH-1:0] prog_data,
    output logic                   busy,
    output logic                   done,
    output logic                   run_enable,
    output logic [BL_W-1:0]        bits_left
);

    localparam int SLICES = slices_per_byte(BYTE_WIDTH, INPUT_WIDTH);
    localparam int CNT_W  = $clog2(SLICES + 1);

    logic [1:0]       state;
    logic             handshake;
    logic             last_slice;
    logic [CNT_W-1:0] load_count;

    assign in_ready   = (state == ST_WAIT_BYTE) && !abort;
    assign handshake  = in_valid && in_ready;
    assign run_enable = done && !busy;

    // A trailing partial byte only contributes the bits the image still needs.
    always_comb begin
        load_count = CNT_W'(SLICES);
        if (bits_left < BL_W'(BYTE_WIDTH))
            load_count = CNT_W'(bits_left / BL_W'(INPUT_WIDTH));
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bits_left <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_WAIT_BYTE;
                        bits_left <= BL_W'(MEM_WIDTH);
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_WAIT_BYTE: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        bits_left <= '0;
                    end else if (handshake) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        bits_left <= '0;
                    end else begin
                        bits_left <= bits_left - BL_W'(INPUT_WIDTH);
                        if (last_slice) begin
                            if (bits_left == BL_W'(INPUT_WIDTH)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_WAIT_BYTE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    byte_serializer #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .BYTE_WIDTH  (BYTE_WIDTH),
        .CNT_W       (CNT_W)
    ) u_serializer (
        .clock       (clock),
        .rst         (rst),
        .clear       (abort && busy),
        .load        (handshake),
        .load_data   (in_data),
        .load_count  (load_count),
        .slice_valid (prog_enable),
        .slice       (prog_data),
        .last_slice  (last_slice)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: default image (128 x 1 bit) and a
// 2-bit-slice image of 100 bits, checked against a bit-stream reference model.
module tb_prog_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst, start, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, prog_enable, busy, done, run_enable;
    logic [0:0] prog_data;
    logic [7:0] bits_left;

    logic       start2, abort2, in_valid2;
    logic [7:0] in_data2;
    logic       in_ready2, prog_enable2, busy2, done2, run_enable2;
    logic [1:0] prog_data2;
    logic [6:0] bits_left2;

    prog_loader u_dut (
        .clock(clock), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .prog_enable(prog_enable), .prog_data(prog_data), .busy(busy),
        .done(done), .run_enable(run_enable), .bits_left(bits_left)
    );

    // 28*2 + 4*(2+2+4+1+2) = 100 image bits, shifted 2 at a time.
    prog_loader #(.INPUT_WIDTH(2), .STATE_COUNT(4), .COUNTER_WIDTH(28)) u_dut2 (
        .clock(clock), .rst(rst), .start(start2), .abort(abort2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .prog_enable(prog_enable2), .prog_data(prog_data2), .busy(busy2),
        .done(done2), .run_enable(run_enable2), .bits_left(bits_left2)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int overlap = 0;
    int cap1[$];
    int cap2[$];
    int exp_q[$];
    logic [7:0] bytes_q[$];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (prog_enable) cap1.push_back(int'(prog_data));
        if (prog_enable2) cap2.push_back(int'(prog_data2));
        if ((in_ready && prog_enable) || (in_ready && !busy)) overlap++;
    end

    // Reference: concatenate bytes MSB first, keep the first mem bits, cut into iw-bit slices.
    function automatic void build_exp(input int mem, input int iw);
        exp_q.delete();
        for (int i = 0; i < mem / iw; i++) begin
            int v;
            v = 0;
            for (int b = 0; b < iw; b++) begin
                int j;
                logic [7:0] t;
                j = i * iw + b;
                t = bytes_q[j / 8];
                v = (v << 1) | int'(t[7 - (j % 8)]);
            end
            exp_q.push_back(v);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic random_bytes(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
    endtask

    task automatic feed(input int first, input int last, input int gaps);
        int  gap_mask[64];
        int  n;
        int  tmo;
        bit  acc;
        foreach (gap_mask[i]) gap_mask[i] = 0;
        n = 0;
        while (n < gaps) begin
            int p;
            p = int'($urandom_range(last - 1, first));
            if (gap_mask[p] == 0) begin
                gap_mask[p] = 1;
                n++;
            end
        end
        for (int k = first; k < last; k++) begin
            if (gap_mask[k] != 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(4, 1)) tick();
            end
            in_valid = 1'b1;
            in_data  = bytes_q[k];
            acc = 1'b0;
            tmo = 0;
            while (!acc && tmo < 40) begin
                acc = in_ready;
                tick();
                tmo++;
            end
            in_valid = 1'b0;
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL feed_timeout byte %0d: in_ready got 0, expected 1", k);
                return;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; in_valid = 0; in_data = 0;
        start2 = 0; abort2 = 0; in_valid2 = 0; in_data2 = 0;
        tick(); tick();
        checks++;
        if ({in_ready, prog_enable, prog_data, busy, done, run_enable, bits_left} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {in_ready, prog_enable, prog_data, busy, done, run_enable, bits_left});
        end
        checks++;
        if ({in_ready2, prog_enable2, prog_data2, busy2, done2, run_enable2, bits_left2} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs2: got %b, expected all zero",
                     {in_ready2, prog_enable2, prog_data2, busy2, done2, run_enable2, bits_left2});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        int c0;
        int mism;
        bytes_q.delete();
        for (int i = 0; i < 16; i++) bytes_q.push_back(8'(i));
        build_exp(128, 1);
        cap1.delete();
        start_pulse();
        c0 = cyc;
        feed(0, 16, 0);
        wait_done();
        checks++;
        if (cyc - c0 !== 16 * 9) begin
            errors++;
            $display("FAIL full_latency: got %0d cycles, expected %0d", cyc - c0, 16 * 9);
        end
        checks++;
        if (cap1.size() !== 128) begin
            errors++;
            $display("FAIL full_count: got %0d, expected 128", cap1.size());
        end
        mism = -1;
        for (int i = 0; i < exp_q.size() && i < cap1.size(); i++)
            if (mism < 0 && cap1[i] !== exp_q[i]) mism = i;
        checks++;
        if (mism >= 0) begin
            errors++;
            $display("FAIL full_stream slice %0d: got %0d, expected %0d", mism, cap1[mism], exp_q[mism]);
        end
        checks++;
        if ({done, run_enable, busy, bits_left} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL full_status done/run/busy/bits: got %b %b %b %0d, expected 1 1 0 0",
                     done, run_enable, busy, bits_left);
        end
    endtask

    task automatic test_gaps();
        int mism;
        random_bytes(16);
        build_exp(128, 1);
        cap1.delete();
        overlap = 0;
        start_pulse();
        feed(0, 16, 5);
        wait_done();
        checks++;
        if (cap1.size() !== 128) begin
            errors++;
            $display("FAIL gaps_count: got %0d, expected 128", cap1.size());
        end
        mism = -1;
        for (int i = 0; i < exp_q.size() && i < cap1.size(); i++)
            if (mism < 0 && cap1[i] !== exp_q[i]) mism = i;
        checks++;
        if (mism >= 0) begin
            errors++;
            $display("FAIL gaps_stream slice %0d: got %0d, expected %0d", mism, cap1[mism], exp_q[mism]);
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL gaps_in_ready_outside_wait: got %0d cycles, expected 0", overlap);
        end
        checks++;
        if (run_enable !== 1'b1) begin
            errors++;
            $display("FAIL gaps_run_enable: got %b, expected 1", run_enable);
        end
    endtask

    task automatic test_abort();
        int mism;
        random_bytes(16);
        build_exp(128, 1);
        start_pulse();
        feed(0, 5, 0);
        tick(); tick();
        checks++;
        if ({prog_enable, prog_data, bits_left} !== {1'b1, 1'(exp_q[4 * 8 + 2]), 8'd94}) begin
            errors++;
            $display("FAIL abort_pre en/data/bits: got %b %b %0d, expected 1 %0d 94",
                     prog_enable, prog_data, bits_left, exp_q[34]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({prog_enable, busy, done, run_enable, bits_left} !== 12'd0) begin
            errors++;
            $display("FAIL abort_post en/busy/done/run/bits: got %b %b %b %b %0d, expected all 0",
                     prog_enable, busy, done, run_enable, bits_left);
        end
        random_bytes(16);
        build_exp(128, 1);
        cap1.delete();
        start_pulse();
        feed(0, 16, 0);
        wait_done();
        mism = (cap1.size() == 128) ? -1 : 0;
        for (int i = 0; i < exp_q.size() && i < cap1.size(); i++)
            if (mism < 0 && cap1[i] !== exp_q[i]) mism = i;
        checks++;
        if (mism >= 0 || run_enable !== 1'b1) begin
            errors++;
            $display("FAIL abort_reload: got %0d slices, first bad %0d, run %b; expected 128, none, 1",
                     cap1.size(), mism, run_enable);
        end
    endtask

    task automatic test_reset_mid();
        random_bytes(16);
        start_pulse();
        feed(0, 1, 0);
        tick();
        checks++;
        if (prog_enable !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre prog_enable: got %b, expected 1", prog_enable);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, prog_enable, prog_data, busy, done, run_enable, bits_left} !== 14'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b, expected all zero",
                     {in_ready, prog_enable, prog_data, busy, done, run_enable, bits_left});
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, bits_left} !== {1'b1, 8'd128}) begin
            errors++;
            $display("FAIL idle_start_abort busy/bits: got %b %0d, expected 1 128", busy, bits_left);
        end
        in_valid = 1'b1; in_data = 8'hA5; abort = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_masks_ready: got %b, expected 0", in_ready);
        end
        tick();
        abort = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if ({prog_enable, busy, bits_left} !== 10'd0) begin
            errors++;
            $display("FAIL wait_abort en/busy/bits: got %b %b %0d, expected 0 0 0", prog_enable, busy, bits_left);
        end
    endtask

    task automatic test_start_during_shift();
        int bl;
        int mism;
        random_bytes(16);
        build_exp(128, 1);
        cap1.delete();
        start_pulse();
        feed(0, 3, 0);
        tick();
        bl = int'(bits_left);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, bits_left} !== {1'b1, 8'(bl - 1)}) begin
            errors++;
            $display("FAIL shift_start busy/bits: got %b %0d, expected 1 %0d", busy, bits_left, bl - 1);
        end
        feed(3, 16, 0);
        wait_done();
        mism = (cap1.size() == 128) ? -1 : 0;
        for (int i = 0; i < exp_q.size() && i < cap1.size(); i++)
            if (mism < 0 && cap1[i] !== exp_q[i]) mism = i;
        checks++;
        if (mism >= 0) begin
            errors++;
            $display("FAIL shift_start_stream: got %0d slices, first bad %0d; expected 128, none", cap1.size(), mism);
        end
    endtask

    task automatic test_reload();
        checks++;
        if (run_enable !== 1'b1) begin
            errors++;
            $display("FAIL reload_pre run_enable: got %b, expected 1", run_enable);
        end
        random_bytes(16);
        build_exp(128, 1);
        cap1.delete();
        start_pulse();
        checks++;
        if ({run_enable, done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL reload_start run/done/busy: got %b %b %b, expected 0 0 1", run_enable, done, busy);
        end
        feed(0, 16, 0);
        checks++;
        if (run_enable !== 1'b0) begin
            errors++;
            $display("FAIL reload_mid run_enable: got %b, expected 0", run_enable);
        end
        wait_done();
        checks++;
        if (run_enable !== 1'b1 || cap1.size() !== 128) begin
            errors++;
            $display("FAIL reload_end run/count: got %b %0d, expected 1 128", run_enable, cap1.size());
        end
    endtask

    task automatic test_width2();
        int mism;
        int tmo;
        bit acc;
        random_bytes(12);
        bytes_q.push_back(8'hF3);
        build_exp(100, 2);
        cap2.delete();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 13; k++) begin
            in_valid2 = 1'b1;
            in_data2  = bytes_q[k];
            acc = 1'b0;
            tmo = 0;
            while (!acc && tmo < 40) begin
                acc = in_ready2;
                tick();
                tmo++;
            end
            in_valid2 = 1'b0;
        end
        tmo = 0;
        while (!done2 && tmo < 100) begin
            tick();
            tmo++;
        end
        checks++;
        if (cap2.size() !== 50) begin
            errors++;
            $display("FAIL w2_count: got %0d, expected 50", cap2.size());
        end
        mism = -1;
        for (int i = 0; i < exp_q.size() && i < cap2.size(); i++)
            if (mism < 0 && cap2[i] !== exp_q[i]) mism = i;
        checks++;
        if (mism >= 0) begin
            errors++;
            $display("FAIL w2_stream slice %0d: got %0d, expected %0d", mism, cap2[mism], exp_q[mism]);
        end
        checks++;
        if (cap2.size() < 50 || cap2[48] !== 3 || cap2[49] !== 3) begin
            errors++;
            $display("FAIL w2_partial_tail: got %0d slices, expected last two slices 3 3", cap2.size());
        end
        checks++;
        if ({done2, run_enable2, busy2, bits_left2} !== {1'b1, 1'b1, 1'b0, 7'd0}) begin
            errors++;
            $display("FAIL w2_status done/run/busy/bits: got %b %b %b %0d, expected 1 1 0 0",
                     done2, run_enable2, busy2, bits_left2);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_start_abort_idle();
        test_start_during_shift();
        test_reload();
        test_width2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
